// File: rtl/fp32_div_if.sv
// Operand/result bundle for fp32_div: clock enable, start/busy/done handshake,
// x1/x2 operands and the y quotient.
interface fp32_div_if;
  logic        en;
  logic        start;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        busy;
  logic        done;
  logic [31:0] y;

  modport master (output en, start, x1, x2, input busy, done, y);
  modport slave  (input en, start, x1, x2, output busy, done, y);
endinterface

// File: rtl/fp32_div.sv
// Iterative fp32 divider: radix-2 restoring division, fixed 29-cycle latency.
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; default truncates.
module fp32_div (
  input  logic        clk,
  input  logic        rst,
  fp32_div_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, PREP, DIV, NORM, PACK} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] xa, xb, y_r, spec_y;
  logic        busy_r, done_r, sign, spec, stk;
  logic [24:0] rem;
  logic [23:0] dv;
  logic [25:0] q;
  logic [9:0]  e;

  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic found;
    lzc24 = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      lzc24 = lzc24 + 5'd1;
      end
    end
  endfunction

  // Operand unpack and denormal normalisation, consumed in PREP
  logic [23:0] m1_raw, m2_raw, m1n, m2n;
  logic [4:0]  lz1, lz2;
  logic [9:0]  e1, e2;
  logic        inf_c, zero_c;
  always_comb begin
    m1_raw = {|xa[30:23], xa[22:0]};
    m2_raw = {|xb[30:23], xb[22:0]};
    lz1    = lzc24(m1_raw);
    lz2    = lzc24(m2_raw);
    m1n    = m1_raw << lz1;
    m2n    = m2_raw << lz2;
    e1     = (|xa[30:23] ? {2'b00, xa[30:23]} : 10'd1) - 10'd127 - {5'd0, lz1};
    e2     = (|xb[30:23] ? {2'b00, xb[30:23]} : 10'd1) - 10'd127 - {5'd0, lz2};
    inf_c  = (&xa[30:23]) | (&xb[30:23]) | ~|xb[30:0];
    zero_c = ~|xa[30:0];
  end

  // One restoring step; the partial remainder stays below 2*dv < 2^25
  logic        ge;
  logic [23:0] diff;
  logic [24:0] rem_nx;
  always_comb begin
    ge     = rem >= {1'b0, dv};
    diff   = rem[23:0] - dv;
    rem_nx = ge ? {diff, 1'b0} : {rem[23:0], 1'b0};
  end

  // Exponent bias, denormal shift, optional rounding
  logic [9:0]  b, sh;
  logic [26:0] vec, shv;
  logic [25:0] qs;
  logic [7:0]  expf;
  logic [30:0] mag;
  logic        ss, lost, ovf;
  logic [31:0] res;
  always_comb begin
    b    = e + 10'd127;
    sh   = 10'd1 - b;
    vec  = {q, stk};
    shv  = vec;
    lost = 1'b0;
    qs   = q;
    ss   = stk;
    expf = b[7:0];
    ovf  = $signed(b) > 10'sd254;
    if ($signed(b) <= 10'sd0) begin
      if (sh > 10'd26) begin
        shv  = 27'd0;
        lost = |vec;
      end else begin
        shv  = vec >> sh;
        lost = |(vec & ~(27'h7FF_FFFF << sh));
      end
      qs   = shv[26:1];
      ss   = shv[0] | lost;
      expf = 8'd0;
    end
    mag = {expf, qs[24:2]};
`ifdef FP32_DIV_ROUND_EN
    // Carry out of the fraction walks naturally into the exponent field
    mag = mag + {30'd0, qs[1] & (qs[0] | ss | qs[2])};
`endif
    res = spec ? spec_y : ovf ? {sign, 8'hFF, 23'h0} : {sign, mag};
  end

`ifdef FP32_DIV_ROUND_EN
  logic unused_bits;
  assign unused_bits = qs[25];
`else
  logic unused_bits;
  assign unused_bits = ^{qs[25], qs[1:0], ss};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      xa     <= 32'd0;
      xb     <= 32'd0;
      y_r    <= 32'd0;
      spec_y <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sign   <= 1'b0;
      spec   <= 1'b0;
      stk    <= 1'b0;
      rem    <= 25'd0;
      dv     <= 24'd0;
      q      <= 26'd0;
      e      <= 10'd0;
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            xa     <= bus.x1;
            xb     <= bus.x2;
            busy_r <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          sign   <= xa[31] ^ xb[31];
          spec   <= inf_c | zero_c;
          spec_y <= inf_c ? {xa[31] ^ xb[31], 8'hFF, 23'h0} : {xa[31] ^ xb[31], 31'h0};
          rem    <= {1'b0, m1n};
          dv     <= m2n;
          e      <= e1 - e2;
          q      <= 26'd0;
          cnt    <= 5'd0;
          state  <= DIV;
        end
        DIV: begin
          q   <= {q[24:0], ge};
          rem <= rem_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= NORM;
        end
        NORM: begin
          if (!q[25]) begin
            q <= {q[24:0], 1'b0};
            e <= e - 10'd1;
          end
          stk   <= |rem;
          state <= PACK;
        end
        PACK: begin
          y_r    <= res;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y    = y_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_fp32_div.sv
// Directed bench for fp32_div: scoreboard of expected quotients, latency,
// stall, busy-start and async reset checks.
module tb_fp32_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fp32_div_if bus ();
  fp32_div dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

`ifdef FP32_DIV_ROUND_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    bus.x1 = a;
    bus.x2 = b;
    bus.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    int busy_low = 0;
    logic [31:0] e;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy !== 1'b1) busy_low++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy_hi"}, busy_low, 0);
    chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
    chk({tag, "_y"}, bus.y, e);
    @(negedge clk);
    chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int k = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) k++;
    end
    chk(tag, k, 0);
  endtask

  initial begin
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.x1 = 32'd0;
    bus.x2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_y", bus.y, 32'd0);
    rst = 1'b0;

    issue(32'h40C00000, 32'h40000000, 32'h40400000); wait_done("div6_2", 29);
    issue(32'h3F800000, 32'h40400000, THIRD);        wait_done("third", 29);
    issue(32'hBF800000, 32'h00000000, 32'hFF800000); wait_done("div_zero", 29);
    issue(32'h00000000, 32'h40000000, 32'h00000000); wait_done("zero_num", 29);
    issue(32'h7F800000, 32'h3F800000, 32'h7F800000); wait_done("inf_num", 29);
    issue(32'h7F000000, 32'h3E800000, 32'h7F800000); wait_done("overflow", 29);
    issue(32'h00800000, 32'h40000000, 32'h00400000); wait_done("denorm_out", 29);
    issue(32'h00400000, 32'h00200000, 32'h40000000); wait_done("denorm_in", 29);

    // Stall for 5 cycles in the middle of the division
    issue(32'h3F800000, 32'h40400000, THIRD);
    repeat (10) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_y", bus.y, 32'h40000000);
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.en = 1'b1;
    wait_done("stall", 19);

    // Start pulsed while busy must be dropped
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (5) @(negedge clk);
    bus.x1 = 32'h3F800000;
    bus.x2 = 32'h40400000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start", 23);
    no_done("busy_start_extra", 40);

    // Asynchronous reset mid-operation
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_y", bus.y, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    no_done("arst_no_done", 40);

    issue(32'h3F800000, 32'h3F800000, 32'h3F800000); wait_done("after_rst", 29);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp32_div.md
# fp32_div

Iterative IEEE-754 single-precision divider, the inverse-operation companion to the team's four-stage FP32 multiplier. It sits beside the multiplier in the arithmetic datapath and computes y = x1 / x2 with the same operand/result packing and special-value policy. A start/busy/done handshake wraps a radix-2 restoring-division state machine. Latency is fixed at 29 cycles while `en` stays high.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; low freezes every register, and `start` is ignored
- start  in  1  request; sampled only in IDLE with en=1
- x1  in  32  dividend, IEEE-754 fp32; captured on the accepted start edge
- x2  in  32  divisor, fp32; captured with x1
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; y is valid from this cycle until the next done
- y  out  32  quotient, fp32

## Operation
- States: IDLE → PREP → DIV (26 iterations) → NORM → PACK → IDLE.
- Reset: state=IDLE, y=0x00000000, done=0, busy=0, iteration counter=0. Reset mid-operation aborts immediately, and no done is produced.
- IDLE: on start=1 and en=1, capture x1/x2 and go to PREP. Outside IDLE, start is ignored and never queued.
- Sign: x1[31]^x2[31] for every result.
- Special cases, decided in PREP, in priority order. The operation still runs the full latency.
  - Any operand with exp=0xFF, or x2[30:0]=0: y={sign,8'hFF,23'h0}.
  - Otherwise, if x1[30:0]=0: y={sign,31'h0}.
  - No NaN is ever produced.
- PREP:
  - Mantissa = {exp≠0, frac} (24 b). Effective exponent = max(exp,1)−127.
  - Denormals are normalised with a single-cycle leading-zero shift so that bit 23 is set. The shift amount is subtracted from the exponent.
  - E = e1 − e2 (10-bit signed).
- DIV: restoring division of m1 by m2, one quotient bit per cycle, 26 bits q[25:0]. q has weight 2^0 at q[25].
  - sticky = (final remainder ≠ 0).
  - q lies in [2^24, 2^26).
- NORM: if q[25]=0, shift q left by 1 and decrement E.
- PACK: compute biased B = E + 127.
  - B ≥ 255: infinity.
  - B ≤ 0: denormal. Right-shift {q, sticky} by (1−B) and set the exponent field to 0. Shifts > 26 flush to 0, with sign kept. Shifted-out bits OR into sticky.
  - Otherwise: exponent = B[7:0], fraction = q[24:2].

## Timing
- Edge 0: start accepted; busy=1 after this edge.
- Edge 1: PREP.
- Edges 2–27: DIV iterations.
- Edge 28: NORM.
- Edge 29: PACK. y is registered, done=1 and busy=0 after this edge.
- done drops after edge 30. A start presented in the done cycle is accepted at edge 30, so back-to-back throughput is one result per 30 cycles.
- Each cycle with en=0 extends every count above by one. done and busy hold their values during a stall, so a done pulse that meets en=0 stays high until the next enabled edge.
- y holds its value until the next PACK or a reset.

## Configuration
- FP32_DIV_ROUND_EN defined:
  - Round-to-nearest-even using guard q[1], round/sticky (q[0]|sticky), and lsb q[2]. Denormal results use the post-shift bits.
  - A mantissa carry increments the exponent. A carry from denormal 0x7FFFFF produces the smallest normal. Reaching 255 produces infinity.
- Undefined: truncation, with guard/sticky discarded. This matches the multiplier.

## Test plan
- x1=0x40C00000 (6.0), x2=0x40000000 (2.0) → y=0x40400000. done rises exactly 29 enabled cycles after the start edge, and busy is high for the 29 cycles in between.
- x1=0x3F800000, x2=0x40400000 (1/3) → y=0x3EAAAAAB with FP32_DIV_ROUND_EN, 0x3EAAAAAA without.
- Special values:
  - 0xBF800000 / 0x00000000 → 0xFF800000.
  - 0x00000000 / 0x40000000 → 0x00000000.
  - 0x7F800000 / 0x3F800000 → 0x7F800000.
- Range limits:
  - 0x7F000000 / 0x3E800000 → 0x7F800000 (overflow).
  - 0x00800000 / 0x40000000 → 0x00400000 (denormal result).
  - 0x00400000 / 0x00200000 → 0x40000000 (denormal inputs).
- Handshake:
  - Hold en=0 for 5 cycles mid-DIV → done is delayed by exactly 5 cycles and y is unchanged.
  - Pulse start while busy → ignored, and only one done is produced.
  - Assert rst at cycle 10 → busy=0, done=0, y=0 asynchronously, and no done follows.
